mode_led_driver: RTL and testbench

Output-side consumer of the 2-bit key-toggled mode word (modeSelect). It synchronizes modeSelect into the system clock domain and drives the board LED bank with one of four timed patterns: off, binary count, bouncing light, or blink. All pattern timing comes from an internal step prescaler, so the display is fully synchronous even though modeSelect arrives from asynchronous key logic.

---
 rtl/mode_pkg.sv | 27 ++
 rtl/mode_led_driver_if.sv | 23 ++
 rtl/mode_led_driver_step_prescaler.sv | 35 +++
 rtl/mode_led_driver.sv | 112 +++++++++++
 tb/tb_mode_led_driver.sv | 129 ++++++++++++
 5 files changed

// File: rtl/mode_pkg.sv
// Shared mode encodings and per-mode initial LED patterns for timed display blocks.
package mode_pkg;

    typedef enum logic [1:0] {
        MODE_OFF    = 2'b00,
        MODE_COUNT  = 2'b01,
        MODE_BOUNCE = 2'b10,
        MODE_BLINK  = 2'b11
    } mode_e;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    localparam int unsigned PAT_MAX_W = 64;

    // Pattern is returned at full width; callers keep the low w bits.
    function automatic logic [PAT_MAX_W-1:0] init_pattern(input mode_e m, input int unsigned w);
        logic [PAT_MAX_W-1:0] ones;
        ones = {PAT_MAX_W{1'b1}} >> (PAT_MAX_W - w);
        case (m)
            MODE_BOUNCE: init_pattern = {{(PAT_MAX_W-1){1'b0}}, 1'b1};
            MODE_BLINK:  init_pattern = ones;
            default:     init_pattern = '0;
        endcase
    endfunction

endpackage

// File: rtl/mode_led_driver_if.sv
// Mode request in, LED bank / step pulse / committed mode out.
interface mode_led_if #(
    parameter int unsigned LED_W = 10
);
    logic [1:0]       modeSelect;
    logic [LED_W-1:0] leds;
    logic             step;
    logic [1:0]       modeActive;

    modport master (
        output modeSelect,
        input  leds,
        input  step,
        input  modeActive
    );

    modport slave (
        input  modeSelect,
        output leds,
        output step,
        output modeActive
    );
endinterface

// File: rtl/mode_led_driver_step_prescaler.sv
// Free-running 0..DIV-1 counter with a registered one-cycle tick on wrap.
// clear restarts the count and suppresses the tick; terminal tells the parent the tick edge is now.
module step_prescaler #(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick,
    output logic terminal
);
    localparam int unsigned CW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] r_count;
    logic          r_tick;
    logic          w_at_last;

    assign w_at_last = (r_count == LAST);
    assign terminal  = w_at_last && !clear;
    assign tick      = r_tick;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_count <= '0;
            r_tick  <= 1'b0;
        end else if (w_at_last) begin
            r_count <= '0;
            r_tick  <= 1'b1;
        end else begin
            r_count <= r_count + CW'(1);
            r_tick  <= 1'b0;
        end
    end
endmodule

// File: rtl/mode_led_driver.sv
// Drives the LED bank with off / count / bounce / blink patterns chosen by an async mode word.
// All outputs registered; mode changes commit on the 3rd edge after modeSelect is first sampled.
module mode_led_driver
    import mode_pkg::*;
#(
    parameter int unsigned CLK_HZ  = 50000000,
    parameter int unsigned STEP_HZ = 4,
    parameter int unsigned LED_W   = 10
) (
    input  logic     clk,
    input  logic     reset,
    mode_led_if.slave bus
);
    localparam int unsigned DIV = CLK_HZ / STEP_HZ;
    localparam logic [LED_W-1:0] ONE = LED_W'(1);

    logic [1:0]           r_sync1;
    logic [1:0]           r_sync2;
    mode_e                r_mode;
    logic [LED_W-1:0]     r_leds;
    logic                 r_dir;

    mode_e                w_mode_next;
    logic                 w_change;
    logic                 w_adv;
    logic                 w_tick;
    logic [LED_W-1:0]     w_leds_next;
    logic                 w_dir_next;
    logic [PAT_MAX_W-1:0] w_init_wide;
    logic [LED_W-1:0]     w_init;
    logic                 w_onehot;
    logic                 w_go_down;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 2'b00;
            r_sync2 <= 2'b00;
        end else begin
            r_sync1 <= bus.modeSelect;
            r_sync2 <= r_sync1;
        end
    end

    // A change edge clears the prescaler, so it also masks a coincident step.
    step_prescaler #(.DIV(DIV)) u_prescaler (
        .clk      (clk),
        .reset    (reset),
        .clear    (w_change),
        .tick     (w_tick),
        .terminal (w_adv)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mode <= MODE_OFF;
        end else begin
            r_mode <= w_mode_next;
        end
    end

    always_comb begin
        w_change    = (mode_e'(r_sync2) != r_mode);
        w_mode_next = w_change ? mode_e'(r_sync2) : r_mode;
    end

    assign w_init_wide = init_pattern(mode_e'(r_sync2), LED_W);
    assign w_init      = w_init_wide[LED_W-1:0];
    assign w_onehot    = (r_leds != '0) && ((r_leds & (r_leds - ONE)) == '0);
    // Turn around on the end bits so they are shown once, not twice.
    assign w_go_down   = (r_dir == DIR_UP) ? r_leds[LED_W-1] : !r_leds[0];

    always_comb begin
        w_leds_next = r_leds;
        w_dir_next  = r_dir;
        if (w_change) begin
            w_leds_next = w_init;
            w_dir_next  = DIR_UP;
        end else if (w_adv) begin
            case (r_mode)
                MODE_COUNT: w_leds_next = r_leds + ONE;
                MODE_BLINK: w_leds_next = ~r_leds;
                MODE_BOUNCE: begin
                    if (!w_onehot) begin
                        w_leds_next = ONE;
                        w_dir_next  = DIR_UP;
                    end else if (w_go_down) begin
                        w_leds_next = r_leds >> 1;
                        w_dir_next  = DIR_DOWN;
                    end else begin
                        w_leds_next = r_leds << 1;
                        w_dir_next  = DIR_UP;
                    end
                end
                default: w_leds_next = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_leds <= '0;
            r_dir  <= DIR_UP;
        end else begin
            r_leds <= w_leds_next;
            r_dir  <= w_dir_next;
        end
    end

    assign bus.leds       = r_leds;
    assign bus.step       = w_tick;
    assign bus.modeActive = r_mode;
endmodule

// File: tb/tb_mode_led_driver.sv
// Directed bench for mode_led_driver with LED_W=4, DIV=4; outputs sampled on falling edges.
module tb_mode_led_driver;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    mode_led_if #(.LED_W(4)) bus ();

    mode_led_driver #(
        .CLK_HZ  (4),
        .STEP_HZ (1),
        .LED_W   (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]        sel;
        logic [3:0]        init;
        logic [4:0]        n;
        logic [15:0][3:0]  seq;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic idle_then_step(input logic [3:0] prev, input logic [3:0] nxt);
        repeat (3) begin
            @(negedge clk);
            check("idle_step", 32'(bus.step), 32'd0);
            check("idle_leds", 32'(bus.leds), 32'(prev));
        end
        @(negedge clk);
        check("step_pulse", 32'(bus.step), 32'd1);
        check("step_leds", 32'(bus.leds), 32'(nxt));
    endtask

    initial begin
        vec_t       vt [4];
        logic [3:0] bounce_exp [7];
        logic [3:0] blink_exp  [3];
        logic [3:0] prev;

        n_checks = 0;
        n_errors = 0;
        bounce_exp = '{4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h2};
        blink_exp  = '{4'h0, 4'hF, 4'h0};
        for (int v = 0; v < 4; v++) vt[v] = '0;
        vt[0].sel = 2'b01; vt[0].init = 4'h0; vt[0].n = 5'd16;
        for (int i = 0; i < 16; i++) vt[0].seq[i] = 4'(i + 1);
        vt[1].sel = 2'b10; vt[1].init = 4'h1; vt[1].n = 5'd7;
        for (int i = 0; i < 7; i++) vt[1].seq[i] = bounce_exp[i];
        vt[2].sel = 2'b11; vt[2].init = 4'hF; vt[2].n = 5'd3;
        for (int i = 0; i < 3; i++) vt[2].seq[i] = blink_exp[i];
        vt[3].sel = 2'b00; vt[3].init = 4'h0; vt[3].n = 5'd3;

        // Reset state, then OFF mode still emits a step every 4 clocks.
        reset = 1'b1;
        bus.modeSelect = 2'b00;
        repeat (2) @(negedge clk);
        check("rst_leds", 32'(bus.leds), 32'd0);
        check("rst_step", 32'(bus.step), 32'd0);
        check("rst_mode", 32'(bus.modeActive), 32'd0);
        reset = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            check("off_step", 32'(bus.step), (k % 4 == 0) ? 32'd1 : 32'd0);
            check("off_leds", 32'(bus.leds), 32'd0);
            check("off_mode", 32'(bus.modeActive), 32'd0);
        end

        for (int v = 0; v < 4; v++) begin
            bus.modeSelect = vt[v].sel;
            repeat (3) @(negedge clk);
            check("chg_mode", 32'(bus.modeActive), 32'(vt[v].sel));
            check("chg_leds", 32'(bus.leds), 32'(vt[v].init));
            check("chg_step", 32'(bus.step), 32'd0);
            prev = vt[v].init;
            for (int s = 0; s < int'(vt[v].n); s++) begin
                idle_then_step(prev, vt[v].seq[s]);
                prev = vt[v].seq[s];
            end
        end

        // Change edge lands on the prescaler terminal count: change wins.
        @(negedge clk);
        bus.modeSelect = 2'b10;
        repeat (3) @(negedge clk);
        check("coinc_step", 32'(bus.step), 32'd0);
        check("coinc_leds", 32'(bus.leds), 32'h1);
        check("coinc_mode", 32'(bus.modeActive), 32'd2);
        idle_then_step(4'h1, 4'h2);
        idle_then_step(4'h2, 4'h4);

        // Reset in BOUNCE at 0100 with modeSelect held, then re-detection.
        reset = 1'b1;
        @(negedge clk);
        check("mrst_leds", 32'(bus.leds), 32'd0);
        check("mrst_mode", 32'(bus.modeActive), 32'd0);
        check("mrst_step", 32'(bus.step), 32'd0);
        reset = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("resync_leds", 32'(bus.leds), 32'd0);
            check("resync_mode", 32'(bus.modeActive), 32'd0);
        end
        @(negedge clk);
        check("reacq_leds", 32'(bus.leds), 32'h1);
        check("reacq_mode", 32'(bus.modeActive), 32'd2);
        check("reacq_step", 32'(bus.step), 32'd0);
        idle_then_step(4'h1, 4'h2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
